// File: rtl/regfile_read_stage.sv
// ---------------------------------------------------------------------------------------------
// regfile_read_stage
//
// Register-read stage in front of the physical register file. One issued uop per cycle
// presents up to three physical source tags. The stage drives the regfile R0/R1/R2 read
// ports (R0=prs1, R1=prs2, R2=prs3) and captures the operands into a single-entry output
// register. Same-cycle W0/W1 writes are bypassed. While a uop is stalled in the output
// register, its operands follow later writes so they never go stale.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   in_valid/in_ready     issue handshake; in_ready = !out_valid | out_ready
//   in_tag                opaque uop tag, passed through unchanged
//   in_prsN, in_useN      source N address and use flag (N=1..3)
//   flush                 kills the held uop and drops the incoming uop this cycle
//   RK_addr, RK_en        regfile read port K address/enable (K=0..2)
//   RK_data               regfile read data, combinational from RK_addr
//   wbM_en/addr/data      write-port snoop (M=0..1), same signals as regfile port WM
//   out_valid/out_ready   output handshake
//   out_tag, out_rsN_data held uop tag and operands
// ---------------------------------------------------------------------------------------------
module regfile_read_stage #(
    parameter int unsigned NUM_REGS    = 96,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 65,
    parameter int unsigned TAG_W       = 6,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [ADDR_W-1:0] in_prs1,
    input  logic [ADDR_W-1:0] in_prs2,
    input  logic [ADDR_W-1:0] in_prs3,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic              in_use3,
    input  logic              flush,

    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data,
    output logic [ADDR_W-1:0] R1_addr,
    output logic              R1_en,
    input  logic [DATA_W-1:0] R1_data,
    output logic [ADDR_W-1:0] R2_addr,
    output logic              R2_en,
    input  logic [DATA_W-1:0] R2_data,

    input  logic              wb0_en,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_en,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [DATA_W-1:0] out_rs3_data
);

    localparam int NSRC = 3;

    // A source is "legal" when it names a real register that can hold a nonzero value.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < NUM_REGS);
        is_zero  = ZERO_REG_EN && (a == '0);
        return in_range && !is_zero;
    endfunction

    // Per-source views of the flat port list
    logic [ADDR_W-1:0] prs      [NSRC];
    logic              use_src  [NSRC];
    logic [DATA_W-1:0] rd_data  [NSRC];

    assign prs[0]     = in_prs1;
    assign prs[1]     = in_prs2;
    assign prs[2]     = in_prs3;
    assign use_src[0] = in_use1;
    assign use_src[1] = in_use2;
    assign use_src[2] = in_use3;
    assign rd_data[0] = R0_data;
    assign rd_data[1] = R1_data;
    assign rd_data[2] = R2_data;

    // Held uop state. live_q marks operands that track writes (used and legal).
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [ADDR_W-1:0] addr_q   [NSRC];
    logic [ADDR_W-1:0] addr_d   [NSRC];
    logic              live_q   [NSRC];
    logic              live_d   [NSRC];
    logic [DATA_W-1:0] data_q   [NSRC];
    logic [DATA_W-1:0] data_d   [NSRC];

    logic              accept;
    logic              src_live [NSRC];
    logic              ren      [NSRC];
    logic [DATA_W-1:0] cap_val  [NSRC];
    logic [DATA_W-1:0] snp_val  [NSRC];

    assign in_ready = !valid_q || out_ready;

    // Reset gates accept so no read port fires while reset is high.
    assign accept = in_valid && in_ready && !flush && !reset;

    always_comb begin
        for (int n = 0; n < NSRC; n++) begin
            src_live[n] = use_src[n] && legal(prs[n]);
            ren[n]      = accept && src_live[n];

            // Capture path: W1 beats W0 beats the array read, matching the regfile.
            cap_val[n] = '0;
            if (src_live[n]) begin
                if (wb1_en && (wb1_addr == prs[n])) begin
                    cap_val[n] = wb1_data;
                end else if (wb0_en && (wb0_addr == prs[n])) begin
                    cap_val[n] = wb0_data;
                end else begin
                    cap_val[n] = rd_data[n];
                end
            end

            // Held path: illegal write addresses never match because live_q implies a legal
            // held address.
            snp_val[n] = data_q[n];
            if (live_q[n]) begin
                if (wb1_en && (wb1_addr == addr_q[n])) begin
                    snp_val[n] = wb1_data;
                end else if (wb0_en && (wb0_addr == addr_q[n])) begin
                    snp_val[n] = wb0_data;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        for (int n = 0; n < NSRC; n++) begin
            addr_d[n] = addr_q[n];
            live_d[n] = live_q[n];
            data_d[n] = data_q[n];
        end

        if (flush) begin
            // Tag and operands are left stale; only valid matters after a flush.
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            tag_d   = in_tag;
            for (int n = 0; n < NSRC; n++) begin
                addr_d[n] = prs[n];
                live_d[n] = src_live[n];
                data_d[n] = cap_val[n];
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            for (int n = 0; n < NSRC; n++) begin
                data_d[n] = snp_val[n];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            for (int n = 0; n < NSRC; n++) begin
                addr_q[n] <= '0;
                live_q[n] <= 1'b0;
                data_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            for (int n = 0; n < NSRC; n++) begin
                addr_q[n] <= addr_d[n];
                live_q[n] <= live_d[n];
                data_q[n] <= data_d[n];
            end
        end
    end

    assign R0_addr = in_prs1;
    assign R1_addr = in_prs2;
    assign R2_addr = in_prs3;
    assign R0_en   = ren[0];
    assign R1_en   = ren[1];
    assign R2_en   = ren[2];

    assign out_valid    = valid_q;
    assign out_tag      = tag_q;
    assign out_rs1_data = data_q[0];
    assign out_rs2_data = data_q[1];
    assign out_rs3_data = data_q[2];

endmodule

// File: tb/tb_regfile_read_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_regfile_read_stage
//
// Bench for regfile_read_stage. The bench owns a 128-entry register array that answers the
// read ports and absorbs legal writes (W1 after W0). The reference rule is simple: a valid
// held operand always equals the current array contents of its register, or 0 if unused or
// illegal. Directed rows, corner sequences and random traffic are all checked against it.
// ---------------------------------------------------------------------------------------------
module tb_regfile_read_stage;

    localparam int AW = 7;
    localparam int DW = 65;
    localparam int TW = 6;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic [AW-1:0] prs [3];
    logic          use_s [3];
    logic          flush;
    logic [AW-1:0] r0_addr, r1_addr, r2_addr;
    logic          r0_en, r1_en, r2_en;
    logic [DW-1:0] r0_data, r1_data, r2_data;
    logic          wb0_en, wb1_en;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_rs1, out_rs2, out_rs3;

    // Bench-side register file; entries 0 and 96..127 hold garbage that must never leak out.
    logic [DW-1:0] rf [128];

    assign r0_data = rf[r0_addr];
    assign r1_data = rf[r1_addr];
    assign r2_data = rf[r2_addr];

    regfile_read_stage dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .in_prs1      (prs[0]),
        .in_prs2      (prs[1]),
        .in_prs3      (prs[2]),
        .in_use1      (use_s[0]),
        .in_use2      (use_s[1]),
        .in_use3      (use_s[2]),
        .flush        (flush),
        .R0_addr      (r0_addr),
        .R0_en        (r0_en),
        .R0_data      (r0_data),
        .R1_addr      (r1_addr),
        .R1_en        (r1_en),
        .R1_data      (r1_data),
        .R2_addr      (r2_addr),
        .R2_en        (r2_en),
        .R2_data      (r2_data),
        .wb0_en       (wb0_en),
        .wb0_addr     (wb0_addr),
        .wb0_data     (wb0_data),
        .wb1_en       (wb1_en),
        .wb1_addr     (wb1_addr),
        .wb1_data     (wb1_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_rs1_data (out_rs1),
        .out_rs2_data (out_rs2),
        .out_rs3_data (out_rs3)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: what the consumer should currently see.
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [AW-1:0] m_addr [3];
    logic          m_live [3];

    // Values sampled at the last negedge, for the directed checks.
    logic [2:0]    smp_en;
    logic          smp_ready;

    function automatic logic legal(input logic [AW-1:0] a);
        return (a >= 1) && (a <= 95);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_op(input int n);
        return m_live[n] ? rf[m_addr[n]] : '0;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the reference at the edge,
    // then check the registered outputs.
    task automatic step();
        logic          acc;
        logic [2:0]    en_a;
        logic [AW-1:0] ad_a [3];
        @(negedge clock);
        en_a    = {r2_en, r1_en, r0_en};
        ad_a[0] = r0_addr;
        ad_a[1] = r1_addr;
        ad_a[2] = r2_addr;
        chk1("in_ready", in_ready, !m_valid || out_ready);
        acc = in_valid && (!m_valid || out_ready) && !flush && !reset;
        for (int n = 0; n < 3; n++) begin
            chk1($sformatf("R%0d_en", n), en_a[n], acc && use_s[n] && legal(prs[n]));
            chkv($sformatf("R%0d_addr", n), DW'(ad_a[n]), DW'(prs[n]));
        end
        smp_en    = en_a;
        smp_ready = in_ready;
        @(posedge clock);
        #1;
        if (reset) begin
            m_valid = 1'b0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_tag   = in_tag;
            for (int n = 0; n < 3; n++) begin
                m_addr[n] = prs[n];
                m_live[n] = use_s[n] && legal(prs[n]);
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (wb0_en && legal(wb0_addr)) rf[wb0_addr] = wb0_data;
        if (wb1_en && legal(wb1_addr)) rf[wb1_addr] = wb1_data;
        chk1("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chkv("out_tag", DW'(out_tag), DW'(m_tag));
            chkv("out_rs1", out_rs1, exp_op(0));
            chkv("out_rs2", out_rs2, exp_op(1));
            chkv("out_rs3", out_rs3, exp_op(2));
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_tag   = '0;
        flush    = 1'b0;
        wb0_en   = 1'b0;
        wb0_addr = '0;
        wb0_data = '0;
        wb1_en   = 1'b0;
        wb1_addr = '0;
        wb1_data = '0;
        for (int n = 0; n < 3; n++) begin
            prs[n]   = '0;
            use_s[n] = 1'b0;
        end
    endtask

    task automatic set_uop(input logic [TW-1:0] tag, input logic [AW-1:0] p1,
                           input logic [AW-1:0] p2, input logic [AW-1:0] p3,
                           input logic [2:0] u);
        in_valid = 1'b1;
        in_tag   = tag;
        prs[0]   = p1;
        prs[1]   = p2;
        prs[2]   = p3;
        for (int n = 0; n < 3; n++) use_s[n] = u[n];
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 127));
        return AW'($urandom_range(0, 12));
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {1'($urandom_range(0, 1)), $urandom, $urandom};
    endfunction

    typedef struct {
        logic          v;
        logic [TW-1:0] tag;
        logic [AW-1:0] p1, p2, p3;
        logic [2:0]    u;
        logic          rdy;
        logic          w0e;
        logic [AW-1:0] w0a;
        logic [DW-1:0] w0d;
        logic          w1e;
        logic [AW-1:0] w1a;
        logic [DW-1:0] w1d;
        logic          ev;
        logic [TW-1:0] etag;
        logic [DW-1:0] e1, e2, e3;
        logic [2:0]    een;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Directed rows; state carries over from one row to the next.
        vecs[0] = '{1, 6'd5, 7'd3, 7'd4, 7'd0,   3'b011, 1, 0, 7'd0, 65'h0, 0, 7'd0, 65'h0,
                    1, 6'd5, 65'h11, 65'h22, 65'h0, 3'b011};
        vecs[1] = '{1, 6'd6, 7'd9, 7'd0, 7'd0,   3'b001, 1, 1, 7'd9, 65'hA, 1, 7'd9, 65'hB,
                    1, 6'd6, 65'hB, 65'h0, 65'h0, 3'b001};
        vecs[2] = '{1, 6'd7, 7'd9, 7'd0, 7'd0,   3'b001, 1, 1, 7'd9, 65'hA, 0, 7'd0, 65'h0,
                    1, 6'd7, 65'hA, 65'h0, 65'h0, 3'b001};
        vecs[3] = '{1, 6'd8, 7'd0, 7'd96, 7'd127, 3'b111, 1, 0, 7'd0, 65'h0, 0, 7'd0, 65'h0,
                    1, 6'd8, 65'h0, 65'h0, 65'h0, 3'b000};
        vecs[4] = '{0, 6'd0, 7'd0, 7'd0, 7'd0,   3'b000, 0, 1, 7'd0, 65'h55, 0, 7'd0, 65'h0,
                    1, 6'd8, 65'h0, 65'h0, 65'h0, 3'b000};
        vecs[5] = '{0, 6'd0, 7'd0, 7'd0, 7'd0,   3'b000, 1, 0, 7'd0, 65'h0, 0, 7'd0, 65'h0,
                    0, 6'd0, 65'h0, 65'h0, 65'h0, 3'b000};

        for (int i = 0; i < 128; i++) begin
            rf[i] = legal(AW'(i)) ? DW'(i * 32'h0101) : {1'b1, 32'hDEAD_BEEF, 32'(i)};
        end
        rf[3] = 65'h11;
        rf[4] = 65'h22;
        rf[9] = 65'h1;
        m_valid = 1'b0;
        m_tag   = '0;
        for (int n = 0; n < 3; n++) begin
            m_addr[n] = '0;
            m_live[n] = 1'b0;
        end

        // Reset state, with a legal uop offered to show reads stay off during reset.
        idle_inputs();
        reset     = 1'b1;
        out_ready = 1'b1;
        set_uop(6'd1, 7'd3, 7'd4, 7'd5, 3'b111);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk1("reset R0_en", r0_en, 1'b0);
        chk1("reset out_valid", out_valid, 1'b0);
        chkv("reset out_tag", DW'(out_tag), '0);
        chkv("reset rs1", out_rs1, '0);
        chkv("reset rs2", out_rs2, '0);
        chkv("reset rs3", out_rs3, '0);
        reset = 1'b0;
        idle_inputs();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            set_uop(vecs[i].tag, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].u);
            in_valid  = vecs[i].v;
            out_ready = vecs[i].rdy;
            wb0_en    = vecs[i].w0e;
            wb0_addr  = vecs[i].w0a;
            wb0_data  = vecs[i].w0d;
            wb1_en    = vecs[i].w1e;
            wb1_addr  = vecs[i].w1a;
            wb1_data  = vecs[i].w1d;
            step();
            chk1($sformatf("vec%0d valid", i), out_valid, vecs[i].ev);
            chkv($sformatf("vec%0d ren", i), DW'(smp_en), DW'(vecs[i].een));
            if (vecs[i].ev) begin
                chkv($sformatf("vec%0d tag", i), DW'(out_tag), DW'(vecs[i].etag));
                chkv($sformatf("vec%0d rs1", i), out_rs1, vecs[i].e1);
                chkv($sformatf("vec%0d rs2", i), out_rs2, vecs[i].e2);
                chkv($sformatf("vec%0d rs3", i), out_rs3, vecs[i].e3);
            end
        end
        idle_inputs();

        // Stall snoop: held prs2=7 picks up a W1 write and stays valid.
        out_ready = 1'b0;
        set_uop(6'd9, 7'd0, 7'd7, 7'd0, 3'b010);
        step();
        idle_inputs();
        wb1_en   = 1'b1;
        wb1_addr = 7'd7;
        wb1_data = 65'h1_0000_0000_0000_0000;
        step();
        chk1("snoop in_ready", smp_ready, 1'b0);
        chk1("snoop valid", out_valid, 1'b1);
        chkv("snoop rs2", out_rs2, 65'h1_0000_0000_0000_0000);
        idle_inputs();
        out_ready = 1'b1;
        step();

        // Streaming: ten back-to-back uops, one out per cycle, tags in order.
        for (int i = 0; i < 10; i++) begin
            set_uop(TW'(10 + i), AW'(i + 1), AW'(i + 20), AW'(i + 40), 3'b111);
            step();
            chk1($sformatf("stream%0d ready", i), smp_ready, 1'b1);
            chk1($sformatf("stream%0d valid", i), out_valid, 1'b1);
            chkv($sformatf("stream%0d tag", i), DW'(out_tag), DW'(10 + i));
        end
        idle_inputs();
        step();

        // Flush while holding, with a uop offered: both gone.
        out_ready = 1'b0;
        set_uop(6'h21, 7'd3, 7'd0, 7'd0, 3'b001);
        step();
        set_uop(6'h3F, 7'd4, 7'd0, 7'd0, 3'b001);
        flush = 1'b1;
        step();
        chk1("flush valid", out_valid, 1'b0);
        idle_inputs();
        step();
        chk1("flush drop", out_valid, 1'b0);

        // Reset during a stall discards the held uop and clears operands.
        set_uop(6'h22, 7'd3, 7'd4, 7'd0, 3'b011);
        step();
        idle_inputs();
        step();
        reset = 1'b1;
        step();
        chk1("stall reset valid", out_valid, 1'b0);
        chkv("stall reset tag", DW'(out_tag), '0);
        chkv("stall reset rs1", out_rs1, '0);
        chkv("stall reset rs2", out_rs2, '0);
        reset = 1'b0;

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            set_uop(TW'($urandom), rand_addr(), rand_addr(), rand_addr(),
                    3'($urandom_range(0, 7)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            wb0_en    = ($urandom_range(0, 1) == 1);
            wb0_addr  = rand_addr();
            wb0_data  = rand_data();
            wb1_en    = ($urandom_range(0, 1) == 1);
            wb1_addr  = ($urandom_range(0, 3) == 0) ? wb0_addr : rand_addr();
            wb1_data  = rand_data();
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
